shift_sequencer: RTL and testbench

- Multi-cycle controller wrapped around a one-position combinational shift step.
- Accepts a command (data word, 2-bit mode, repeat count) over a valid/ready handshake and applies the step once per clock, `count` times.
- Returns the result over a second valid/ready handshake.
- Sits between a command source (CPU-style register block or testbench) and any consumer of shifted words; turns the single-step shifter into an N-position shift/rotate engine.

---
 rtl/shift_seq_pkg.sv | 15 +
 rtl/shift_step.sv | 23 ++
 rtl/shift_sequencer.sv | 92 +++++++++
 tb/tb_shift_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: FSM states and step modes.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] M_HOLD = 2'd0;
  localparam logic [1:0] M_SHL  = 2'd1;
  localparam logic [1:0] M_SHR  = 2'd2;
  localparam logic [1:0] M_ROR  = 2'd3;

endpackage

// File: rtl/shift_step.sv
// One-position combinational shift/rotate step selected by mode.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [1:0]   mode,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_comb begin
    q = d;
    case (mode)
      M_HOLD: q = d;
      M_SHL:  q = {d[N-2:0], 1'b0};
      M_SHR:  q = {1'b0, d[N-1:1]};
      M_ROR:  q = {d[0], d[N-1:1]};
      default: q = d;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Applies shift_step `count` times to a command word, with valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// ready never depends combinationally on valid, and out_data is stable while out_valid is high.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [1:0]    in_mode,
  input  logic [CW-1:0] in_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          busy
);

  // state is kept as a named internal signal so checkers can bind to it
  state_t        state;
  logic [N-1:0]  data_q;
  logic [1:0]    mode_q;
  logic [CW-1:0] remaining;
  logic [N-1:0]  step_q;

  shift_step #(.N(N)) u_step (
    .mode (mode_q),
    .d    (data_q),
    .q    (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      data_q    <= '0;
      mode_q    <= M_HOLD;
      remaining <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            data_q    <= in_data;
            mode_q    <= in_mode;
            remaining <= in_count;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            if (in_count == '0) begin
              // zero count: the latched word is the result
              state     <= S_DONE;
              out_valid <= 1'b1;
              out_data  <= in_data;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          data_q    <= step_q;
          remaining <= remaining - CW'(1);
          if (remaining == CW'(1)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_data  <= step_q;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed table-driven bench for shift_sequencer plus hand sequences for corner cases.
module tb_shift_sequencer;

  localparam int N  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [1:0]    in_mode;
  logic [CW-1:0] in_count;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          busy;

  shift_sequencer #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0]  data;
    logic [1:0]    mode;
    logic [CW-1:0] count;
    logic [N-1:0]  exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // Issue one command, check every cycle until the result, optionally stall in DONE.
  task automatic run_cmd(input logic [N-1:0] d, input logic [1:0] m,
                         input logic [CW-1:0] c, input int hold);
    logic [N-1:0] exp_v;
    logic [N-1:0] held;
    wait_ready();
    in_data  = d;
    in_mode  = m;
    in_count = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < int'(c); i++) begin
      @(negedge clk);
      check("run_out_valid", {31'd0, out_valid}, 32'd0);
      check("run_busy", {31'd0, busy}, 32'd1);
      check("run_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    check("done_out_valid", {31'd0, out_valid}, 32'd1);
    check("done_out_data", {24'd0, out_data}, {24'd0, exp_v});
    check("done_busy", {31'd0, busy}, 32'd1);
    check("done_in_ready", {31'd0, in_ready}, 32'd0);
    held = out_data;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      in_valid = h[0] ? 1'b0 : 1'b1;
      in_data  = 8'h5A;
      in_count = 4'd2;
      @(negedge clk);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_out_data", {24'd0, out_data}, {24'd0, held});
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    // in_valid may be high together with out_ready: only out_ready acts
    in_valid  = (hold > 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_out_valid", {31'd0, out_valid}, 32'd0);
    check("release_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{8'b10110010, 2'd1, 4'd3,  8'b10010000};
    vecs[1]  = '{8'hB2,       2'd2, 4'd2,  8'h2C};
    vecs[2]  = '{8'hB2,       2'd3, 4'd8,  8'hB2};
    vecs[3]  = '{8'h01,       2'd3, 4'd1,  8'h80};
    vecs[4]  = '{8'hA5,       2'd0, 4'd0,  8'hA5};
    vecs[5]  = '{8'hA5,       2'd2, 4'd0,  8'hA5};
    vecs[6]  = '{8'hA5,       2'd0, 4'd5,  8'hA5};
    vecs[7]  = '{8'hFF,       2'd1, 4'd15, 8'h00};
    vecs[8]  = '{8'hFF,       2'd2, 4'd9,  8'h00};
    vecs[9]  = '{8'h81,       2'd3, 4'd4,  8'h18};
    vecs[10] = '{8'h3C,       2'd1, 4'd1,  8'h78};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 2'd0;
    in_count  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_out_data", {24'd0, out_data}, 32'd0);

    // table-driven vectors
    for (int v = 0; v < 11; v++) begin
      exp_q.push_back(vecs[v].exp);
      run_cmd(vecs[v].data, vecs[v].mode, vecs[v].count, 0);
    end

    // backpressure: 4 stalled cycles in DONE with in_valid pulses
    exp_q.push_back(8'h59);
    run_cmd(8'hB2, 2'd3, 4'd1, 4);

    // reset during RUN abandons the command
    wait_ready();
    in_data  = 8'hFF;
    in_mode  = 2'd1;
    in_count = 4'd10;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    pulse_reset();
    repeat (12) begin
      @(negedge clk);
      check("post_rst_no_output", {31'd0, out_valid}, 32'd0);
    end

    // a new command then completes normally
    exp_q.push_back(8'h2C);
    run_cmd(8'hB2, 2'd2, 4'd2, 0);

    // reset while in DONE drops out_valid on that edge
    wait_ready();
    in_data  = 8'h3C;
    in_mode  = 2'd0;
    in_count = 4'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("done_before_rst", {31'd0, out_valid}, 32'd1);
    check("done_before_rst_data", {24'd0, out_data}, 32'h3C);
    pulse_reset();

    exp_q.push_back(8'h78);
    run_cmd(8'h3C, 2'd1, 4'd1, 0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
